// File: rtl/uplane_pkg.sv
// Shared definitions for the U-plane stream arbiter.
//
// Purpose : default widths, the arbiter FSM state encoding and small
//           elaboration-time helpers used by the arbiter and its
//           round-robin selector.
// Contents: UPL_* width defaults, arb_state_t (IDLE/ARB/XFER),
//           idx_width(), rr_distance(), idx_bit_mask().
package uplane_pkg;

    localparam int UPL_DATA_WIDTH  = 128;
    localparam int UPL_TKEEP_WIDTH = UPL_DATA_WIDTH / 8;
    localparam int UPL_NUM_SRC     = 4;
    localparam int UPL_MAX_SRC     = 8;
    localparam int UPL_SEG_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        XFER = 2'd2
    } arb_state_t;

    // Width of a source index; at least one bit so a 1-source build elaborates.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Position of 'src' in the round-robin order that starts just after
    // 'last': the source at last+1 gets distance 0 (highest priority).
    function automatic int rr_distance(input int src, input int last, input int n);
        int d;
        d = src - last - 1;
        if (d < 0) begin
            d = d + n;
        end
        return d;
    endfunction

    // Mask of all source positions whose index has bit 'b' set; OR-reducing
    // a one-hot vector against it yields that bit of the encoded index.
    function automatic logic [UPL_MAX_SRC-1:0] idx_bit_mask(input int b);
        logic [UPL_MAX_SRC-1:0] m;
        m = '0;
        for (int i = 0; i < UPL_MAX_SRC; i++) begin
            if (((i >> b) & 1) == 1) begin
                m = m | (UPL_MAX_SRC'(1) << i);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority selector (purely combinational).
//
// Purpose : pick the first requesting source in round-robin order starting
//           at last_grant+1 (mod NUM_SRC).
// Ports   : req        - request vector, one bit per source
//           last_grant - index of the most recently served source
//           grant      - one-hot winner, all zero when nobody requests
module rr_priority_select
    import uplane_pkg::*;
#(
    parameter int NUM_SRC = UPL_NUM_SRC,
    parameter int IDX_W   = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_SRC-1:0] grant
);

    // Source gi wins when it requests and no requesting peer sits earlier
    // in the rotated order.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [NUM_SRC-1:0] blocked;
            for (genvar gj = 0; gj < NUM_SRC; gj++) begin : g_peer
                assign blocked[gj] = req[gj] &&
                    (rr_distance(gj, int'(last_grant), NUM_SRC) <
                     rr_distance(gi, int'(last_grant), NUM_SRC));
            end
            assign grant[gi] = req[gi] && !(|blocked);
        end
    endgenerate

endmodule

// File: rtl/uplane_stream_arbiter.sv
// U-plane AXI-Stream segment arbiter.
//
// Purpose : multiplexes NUM_SRC AXI-Stream sources onto one packetizer
//           input. A source keeps the grant for a whole segment (until a
//           beat with TUSER=1 is accepted); sources are served round-robin.
//           The output is a single register stage.
// Ports   : clk, reset_n (async, active low)
//           slave_T*      - packed per-source AXI-Stream inputs, TREADY out
//           master_T*     - single-source AXI-Stream output
//           cfg_src_enable- per-source eligibility for new grants
//           stat_grant    - one-hot current grant (zero when not transferring)
//           stat_seg_beats- saturating beat count of the current segment
module uplane_stream_arbiter
    import uplane_pkg::*;
#(
    parameter int DATA_WIDTH  = UPL_DATA_WIDTH,
    parameter int TKEEP_WIDTH = UPL_TKEEP_WIDTH,
    parameter int NUM_SRC     = UPL_NUM_SRC
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]  slave_TDATA,
    input  logic [NUM_SRC-1:0]             slave_TVALID,
    input  logic [NUM_SRC-1:0]             slave_TLAST,
    input  logic [NUM_SRC-1:0]             slave_TUSER,
    input  logic [NUM_SRC*TKEEP_WIDTH-1:0] slave_TKEEP,
    output logic [NUM_SRC-1:0]             slave_TREADY,
    output logic [DATA_WIDTH-1:0]          master_TDATA,
    output logic                           master_TVALID,
    output logic                           master_TLAST,
    output logic                           master_TUSER,
    output logic [TKEEP_WIDTH-1:0]         master_TKEEP,
    input  logic                           master_TREADY,
    input  logic [NUM_SRC-1:0]             cfg_src_enable,
    output logic [NUM_SRC-1:0]             stat_grant,
    output logic [UPL_SEG_CNT_W-1:0]       stat_seg_beats
);

    localparam int IDX_W = idx_width(NUM_SRC);
    localparam logic [UPL_SEG_CNT_W-1:0] SEG_MAX = '1;

    arb_state_t                 state_reg, state_next;
    logic [NUM_SRC-1:0]         grant_reg;
    logic [NUM_SRC-1:0]         rr_grant;
    logic [NUM_SRC-1:0]         eligible;
    logic [IDX_W-1:0]           last_grant_reg;
    logic [IDX_W-1:0]           grant_idx;
    logic [UPL_SEG_CNT_W-1:0]   seg_beats_reg;

    logic [DATA_WIDTH-1:0]      m_data_reg;
    logic [TKEEP_WIDTH-1:0]     m_keep_reg;
    logic                       m_valid_reg;
    logic                       m_last_reg;
    logic                       m_user_reg;

    logic [DATA_WIDTH-1:0]      data_acc [NUM_SRC+1];
    logic [TKEEP_WIDTH-1:0]     keep_acc [NUM_SRC+1];
    logic                       sel_valid, sel_last, sel_user;
    logic                       out_free, xfer, accept, seg_end;

    assign eligible = slave_TVALID & cfg_src_enable;

    rr_priority_select #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .req        (eligible),
        .last_grant (last_grant_reg),
        .grant      (rr_grant)
    );

    // The output register can take a new beat when empty or draining now.
    assign out_free = ~m_valid_reg | master_TREADY;
    assign xfer     = (state_reg == XFER);

    // AND-OR mux on the one-hot grant; grant_reg is the only select, so
    // cfg_src_enable changes cannot disturb a segment in flight.
    assign data_acc[0] = '0;
    assign keep_acc[0] = '0;
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_mux
            assign data_acc[gi+1] = data_acc[gi] |
                (slave_TDATA[gi*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_reg[gi]}});
            assign keep_acc[gi+1] = keep_acc[gi] |
                (slave_TKEEP[gi*TKEEP_WIDTH +: TKEEP_WIDTH] & {TKEEP_WIDTH{grant_reg[gi]}});
            assign slave_TREADY[gi] = xfer & grant_reg[gi] & out_free;
        end

        // One-hot to binary for recording last_grant.
        for (genvar gb = 0; gb < IDX_W; gb++) begin : g_idx
            localparam logic [UPL_MAX_SRC-1:0] BIT_MASK = idx_bit_mask(gb);
            assign grant_idx[gb] = |(grant_reg & BIT_MASK[NUM_SRC-1:0]);
        end
    endgenerate

    assign sel_valid = |(slave_TVALID & grant_reg);
    assign sel_last  = |(slave_TLAST  & grant_reg);
    assign sel_user  = |(slave_TUSER  & grant_reg);

    assign accept  = xfer & out_free & sel_valid;
    assign seg_end = accept & sel_user;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (|eligible) begin
                    state_next = ARB;
                end
            end
            ARB: begin
                // A requester may have vanished since IDLE; fall back
                // without granting anybody.
                state_next = (|eligible) ? XFER : IDLE;
            end
            XFER: begin
                if (seg_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= IDX_W'(NUM_SRC - 1);
            seg_beats_reg  <= '0;
            m_data_reg     <= '0;
            m_keep_reg     <= '0;
            m_valid_reg    <= 1'b0;
            m_last_reg     <= 1'b0;
            m_user_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (state_reg == ARB) begin
                grant_reg <= rr_grant;
            end else if (seg_end) begin
                grant_reg <= '0;
            end

            if (seg_end) begin
                last_grant_reg <= grant_idx;
            end

            if ((state_reg == IDLE) && (state_next == ARB)) begin
                seg_beats_reg <= '0;
            end else if (accept && (seg_beats_reg != SEG_MAX)) begin
                seg_beats_reg <= seg_beats_reg + 1'b1;
            end

            if (accept) begin
                m_data_reg  <= data_acc[NUM_SRC];
                m_keep_reg  <= keep_acc[NUM_SRC];
                m_last_reg  <= sel_last;
                m_user_reg  <= sel_user;
                m_valid_reg <= 1'b1;
            end else if (master_TREADY) begin
                m_valid_reg <= 1'b0;
            end
        end
    end

    assign master_TDATA   = m_data_reg;
    assign master_TKEEP   = m_keep_reg;
    assign master_TVALID  = m_valid_reg;
    assign master_TLAST   = m_last_reg;
    assign master_TUSER   = m_user_reg;
    assign stat_grant     = grant_reg;
    assign stat_seg_beats = seg_beats_reg;

endmodule

// File: tb/tb_uplane_stream_arbiter.sv
// Scoreboard bench for uplane_stream_arbiter: directed segments are queued
// per source, the expected output order is pushed to a scoreboard, and a
// monitor compares every master handshake against it.
module tb_uplane_stream_arbiter;

    localparam int DW = 128;
    localparam int KW = 16;
    localparam int NS = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    logic              clk;
    logic              reset_n;
    logic [NS*DW-1:0]  slave_TDATA;
    logic [NS-1:0]     slave_TVALID;
    logic [NS-1:0]     slave_TLAST;
    logic [NS-1:0]     slave_TUSER;
    logic [NS*KW-1:0]  slave_TKEEP;
    logic [NS-1:0]     slave_TREADY;
    logic [DW-1:0]     master_TDATA;
    logic              master_TVALID;
    logic              master_TLAST;
    logic              master_TUSER;
    logic [KW-1:0]     master_TKEEP;
    logic              master_TREADY;
    logic [NS-1:0]     cfg_src_enable;
    logic [NS-1:0]     stat_grant;
    logic [15:0]       stat_seg_beats;

    beat_t src_q [NS][$];
    beat_t exp_q [$];
    int    hs_q  [$];
    int    cyc = 0;
    int    tests_run = 0;
    int    tests_failed = 0;
    bit    watch2 = 0;
    bit    saw2 = 0;

    uplane_stream_arbiter #(
        .DATA_WIDTH  (DW),
        .TKEEP_WIDTH (KW),
        .NUM_SRC     (NS)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .slave_TDATA    (slave_TDATA),
        .slave_TVALID   (slave_TVALID),
        .slave_TLAST    (slave_TLAST),
        .slave_TUSER    (slave_TUSER),
        .slave_TKEEP    (slave_TKEEP),
        .slave_TREADY   (slave_TREADY),
        .master_TDATA   (master_TDATA),
        .master_TVALID  (master_TVALID),
        .master_TLAST   (master_TLAST),
        .master_TUSER   (master_TUSER),
        .master_TKEEP   (master_TKEEP),
        .master_TREADY  (master_TREADY),
        .cfg_src_enable (cfg_src_enable),
        .stat_grant     (stat_grant),
        .stat_seg_beats (stat_seg_beats)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Beat b (1-based) of segment 'seg' of source 'src': TLAST at last_at,
    // TUSER and a partial keep on the final beat, optional override data.
    function automatic beat_t mk_beat(int src, int seg, int b, int n, int last_at,
                                      logic [DW-1:0] alt, int alt_at);
        beat_t x;
        x.data = (b == alt_at) ? alt
               : ((DW'(src) << 48) | (DW'(seg) << 40) | DW'(b));
        x.keep = (b == n) ? 16'h00FF : 16'hFFFF;
        x.last = (b == last_at);
        x.user = (b == n);
        return x;
    endfunction

    task automatic send_seg(int src, int seg, int n, int last_at, logic [DW-1:0] alt, int alt_at);
        for (int b = 1; b <= n; b++) src_q[src].push_back(mk_beat(src, seg, b, n, last_at, alt, alt_at));
    endtask

    task automatic expect_seg(int src, int seg, int n, int last_at, int upto, logic [DW-1:0] alt, int alt_at);
        for (int b = 1; b <= upto; b++) exp_q.push_back(mk_beat(src, seg, b, n, last_at, alt, alt_at));
    endtask

    // Source driver: pop beats that handshook, present the next head.
    initial begin : drv
        logic [NS-1:0] fire;
        beat_t h;
        slave_TDATA = '0; slave_TVALID = '0; slave_TLAST = '0;
        slave_TUSER = '0; slave_TKEEP = '0;
        forever begin
            @(negedge clk);
            fire = slave_TVALID & slave_TREADY;
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    h = src_q[i][0];
                    slave_TVALID[i] = 1'b1;
                    slave_TDATA[i*DW +: DW] = h.data;
                    slave_TKEEP[i*KW +: KW] = h.keep;
                    slave_TLAST[i] = h.last;
                    slave_TUSER[i] = h.user;
                end else begin
                    slave_TVALID[i] = 1'b0;
                    slave_TDATA[i*DW +: DW] = '0;
                    slave_TKEEP[i*KW +: KW] = '0;
                    slave_TLAST[i] = 1'b0;
                    slave_TUSER[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: compare each master handshake with the scoreboard head.
    initial begin : mon
        beat_t e;
        beat_t a;
        forever begin
            @(negedge clk);
            if (reset_n && master_TVALID && master_TREADY) begin
                a = '{data: master_TDATA, keep: master_TKEEP, last: master_TLAST, user: master_TUSER};
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_beat: got data %0h, expected no beat", master_TDATA);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", a, e);
                end
                hs_q.push_back(cyc);
            end
            if (watch2 && stat_grant[2]) saw2 = 1'b1;
        end
    end

    task automatic reset_start();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        master_TREADY = 1'b1;
        cfg_src_enable = 4'hF;
        for (int i = 0; i < NS; i++) src_q[i].delete();
        exp_q.delete();
        hs_q.delete();
    endtask

    task automatic reset_release();
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic wait_drain(string name, int max);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        chk(name, exp_q.size(), 0);
    endtask

    initial begin : main
        bit found;
        logic [DW-1:0] b2_data;

        reset_n = 1'b0;
        master_TREADY = 1'b1;
        cfg_src_enable = 4'hF;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_slave_ready", slave_TREADY, 0);
        chk("rst_master_valid", master_TVALID, 0);
        chk("rst_master_data", master_TDATA, 0);
        chk("rst_stat_grant", stat_grant, 0);
        chk("rst_seg_beats", stat_seg_beats, 0);

        // Sources 0 and 2 together: 0 first, then 2 after two idle cycles.
        reset_start();
        send_seg(0, 0, 3, 3, '0, 0);
        send_seg(2, 0, 3, 3, '0, 0);
        expect_seg(0, 0, 3, 3, 3, '0, 0);
        expect_seg(2, 0, 3, 3, 3, '0, 0);
        reset_release();
        wait_drain("t1_drain", 60);
        chk("t1_nbeats", hs_q.size(), 6);
        if (hs_q.size() == 6) begin
            chk("t1_contig", hs_q[2] - hs_q[0], 2);
            chk("t1_gap", hs_q[3] - hs_q[2], 3);
        end
        chk("t1_seg_beats", stat_seg_beats, 3);
        chk("t1_idle_grant", stat_grant, 0);

        // TLAST mid-segment does not release the grant.
        reset_start();
        send_seg(1, 0, 4, 2, '0, 0);
        send_seg(3, 0, 2, 2, '0, 0);
        expect_seg(1, 0, 4, 2, 4, '0, 0);
        expect_seg(3, 0, 2, 2, 2, '0, 0);
        reset_release();
        wait_drain("t2_drain", 60);
        chk("t2_nbeats", hs_q.size(), 6);
        if (hs_q.size() == 6) begin
            chk("t2_contig", hs_q[3] - hs_q[0], 3);
            chk("t2_next_src_gap", hs_q[4] - hs_q[3], 3);
        end
        chk("t2_seg_beats", stat_seg_beats, 2);

        // Downstream stall with 'hA5 pending.
        reset_start();
        send_seg(0, 0, 6, 6, 128'hA5, 3);
        expect_seg(0, 0, 6, 6, 6, 128'hA5, 3);
        reset_release();
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk);
            #1;
            if (master_TVALID && master_TDATA == 128'hA5) found = 1'b1;
        end
        chk("t3_found_a5", found, 1);
        master_TREADY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_hold_data", master_TDATA, 128'hA5);
            chk("t3_hold_valid", master_TVALID, 1);
            chk("t3_hold_seg_beats", stat_seg_beats, 3);
        end
        @(posedge clk);
        #1;
        master_TREADY = 1'b1;
        wait_drain("t3_drain", 60);
        chk("t3_nbeats", hs_q.size(), 6);
        chk("t3_seg_beats", stat_seg_beats, 6);

        // Enable mask 1011: order 0,1,3,0 and source 2 never granted.
        reset_start();
        cfg_src_enable = 4'b1011;
        send_seg(0, 0, 1, 1, '0, 0);
        send_seg(0, 1, 1, 1, '0, 0);
        send_seg(1, 0, 1, 1, '0, 0);
        send_seg(2, 0, 1, 1, '0, 0);
        send_seg(3, 0, 1, 1, '0, 0);
        expect_seg(0, 0, 1, 1, 1, '0, 0);
        expect_seg(1, 0, 1, 1, 1, '0, 0);
        expect_seg(3, 0, 1, 1, 1, '0, 0);
        expect_seg(0, 1, 1, 1, 1, '0, 0);
        saw2 = 1'b0;
        watch2 = 1'b1;
        reset_release();
        wait_drain("t4_drain", 80);
        repeat (10) @(posedge clk);
        watch2 = 1'b0;
        chk("t4_src2_granted", saw2, 0);
        chk("t4_nbeats", hs_q.size(), 4);

        // Reset pulse during beat 2 of source 1.
        reset_start();
        send_seg(1, 0, 4, 4, '0, 0);
        expect_seg(1, 0, 4, 4, 1, '0, 0);
        b2_data = (DW'(1) << 48) | DW'(2);
        reset_release();
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk);
            #1;
            if (master_TVALID && master_TDATA == b2_data) found = 1'b1;
        end
        chk("t5_found_beat2", found, 1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_master_valid", master_TVALID, 0);
        chk("t5_rst_master_data", master_TDATA, 0);
        chk("t5_rst_master_keep", master_TKEEP, 0);
        chk("t5_rst_master_last_user", {master_TLAST, master_TUSER}, 0);
        chk("t5_rst_slave_ready", slave_TREADY, 0);
        chk("t5_rst_stat_grant", stat_grant, 0);
        chk("t5_rst_seg_beats", stat_seg_beats, 0);
        chk("t5_beat1_seen", exp_q.size(), 0);
        for (int i = 0; i < NS; i++) src_q[i].delete();
        hs_q.delete();
        send_seg(1, 1, 2, 2, '0, 0);
        send_seg(0, 1, 2, 2, '0, 0);
        expect_seg(0, 1, 2, 2, 2, '0, 0);
        expect_seg(1, 1, 2, 2, 2, '0, 0);
        reset_release();
        wait_drain("t5_drain", 60);

        // Long segment: saturating counter, one beat per cycle.
        reset_start();
        send_seg(0, 0, 70000, 70000, '0, 0);
        expect_seg(0, 0, 70000, 70000, 70000, '0, 0);
        reset_release();
        wait_drain("t6_drain", 70100);
        chk("t6_nbeats", hs_q.size(), 70000);
        if (hs_q.size() == 70000) chk("t6_rate", hs_q[69999] - hs_q[0], 69999);
        chk("t6_seg_beats_sat", stat_seg_beats, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uplane_stream_arbiter.md
UPLANE_STREAM_ARBITER -- requirements
Module: uplane_stream_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 128, is the AXI-Stream data width in bits.
REQ-002 Parameter TKEEP_WIDTH, default 16, is the byte-mask width and SHALL equal DATA_WIDTH/8.
REQ-003 Parameter NUM_SRC, default 4, is the number of requesting sources, range 2..8.
REQ-004 Port clk, input, 1 bit: the single clock.
REQ-005 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port slave_TDATA, input, NUM_SRC*DATA_WIDTH bits: packed source data, source i at slice i.
REQ-007 Port slave_TVALID, input, NUM_SRC bits: per-source valid.
REQ-008 Port slave_TLAST, input, NUM_SRC bits: per-source packet end, passed through unchanged.
REQ-009 Port slave_TUSER, input, NUM_SRC bits: per-source segment end; releases the grant.
REQ-010 Port slave_TKEEP, input, NUM_SRC*TKEEP_WIDTH bits: packed per-source byte masks.
REQ-011 Port slave_TREADY, output, NUM_SRC bits: per-source ready.
REQ-012 Ports master_TDATA, master_TVALID, master_TLAST, master_TUSER and master_TKEEP, outputs with single-source widths, feed the packetizer input.
REQ-013 Port master_TREADY, input, 1 bit: downstream ready.
REQ-014 Port cfg_src_enable, input, NUM_SRC bits: a source is eligible for grant only while its bit is 1.
REQ-015 Port stat_grant, output, NUM_SRC bits: one-hot copy of the current grant; all zero when idle.
REQ-016 Port stat_seg_beats, output, 16 bits: number of beats accepted in the current segment.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, ARB and XFER.
REQ-018 In IDLE, the FSM SHALL move to ARB in the cycle after any bit of (slave_TVALID & cfg_src_enable) is 1.
REQ-019 ARB SHALL select, in one cycle, the first eligible source in round-robin order starting at last_grant+1 modulo NUM_SRC, and move to XFER.
- If no source is eligible in ARB (it dropped valid or was disabled), the FSM SHALL return to IDLE without issuing a grant.
REQ-020 In XFER, slave_TREADY[g] SHALL equal (~master_TVALID | master_TREADY) for the granted source g, and every other slave_TREADY bit SHALL be 0.
REQ-021 The output stage SHALL be one register: a beat accepted at cycle N appears on master_* at cycle N+1, with TDATA, TKEEP, TLAST and TUSER copied bit-exact.
REQ-022 The master output SHALL hold TDATA, TKEEP, TLAST, TUSER and TVALID stable while master_TVALID=1 and master_TREADY=0.
REQ-023 The master output SHALL deassert TVALID after a handshake when no new beat is accepted in the same cycle.
REQ-024 Accepting a beat with slave_TUSER[g]=1 SHALL end the segment:
- last_grant is set to g;
- the FSM returns to IDLE;
- slave_TREADY is all zero the following cycle.
REQ-025 slave_TLAST=1 with TUSER=0 SHALL NOT release the grant.
REQ-026 A granted source dropping TVALID mid-segment SHALL keep the grant; no other source is served until its TUSER beat.
REQ-027 Clearing cfg_src_enable[g] mid-segment SHALL NOT abort the segment; the change takes effect at the next ARB.
REQ-028 stat_seg_beats SHALL count accepted beats, saturate at 16'hFFFF, and clear on entry to ARB.
REQ-029 Idle overhead SHALL be 2 cycles (IDLE then ARB) between segments.
- Sustained throughput within a segment SHALL be 1 beat per cycle while master_TREADY=1.

Reset
REQ-030 On reset_n=0 the block SHALL asynchronously clear:
- state to IDLE;
- last_grant to NUM_SRC-1, so source 0 has first priority;
- slave_TREADY, every master_* output, stat_grant and stat_seg_beats to 0.
REQ-031 Reset asserted mid-segment SHALL drop the in-flight beat.
- The first segment after reset release is granted by the REQ-030 priority.

Structure
REQ-032 The state encodings and the default widths SHALL live in the shared package uplane_pkg.
REQ-033 Round-robin selection SHALL be a separate sub-module rr_priority_select: inputs request vector and last_grant, output one-hot grant, purely combinational.

Verification
REQ-034 Sources 0 and 2 valid together from reset, each sending a 3-beat segment with TUSER on beat 3 -> output shows source 0 beats 1-3, then source 2 beats 1-3, with 2 idle cycles between segments.
REQ-035 Source 1 sends a 4-beat segment with TLAST on beat 2 and TUSER on beat 4, while source 3 is valid -> source 1's 4 beats are contiguous, TLAST is seen on output beat 2 only, and source 3 starts after.
REQ-036 master_TREADY is held 0 for 5 cycles mid-segment, with TDATA=128'hA5 pending -> output holds 128'hA5 for all 5 cycles, no beat is lost or duplicated, and stat_seg_beats is unchanged during the stall.
REQ-037 cfg_src_enable=4'b1011 and all sources valid -> grants follow the order 0,1,3,0, and source 2 is never granted.
REQ-038 reset_n is pulsed low during beat 2 of a segment from source 1 -> all outputs are 0 in the same cycle, and after release source 0 is granted first.
REQ-039 Source 0 streams a 70000-beat segment -> stat_seg_beats saturates at 16'hFFFF, and the data flows 1 beat per cycle throughout.
